// File: rtl/ex_issue_sched.sv
// Execute-stage issue scheduler: RAW scoreboard, load request/wait sequencing, stall accounting.
// state   | meaning
// RUN     | accept and issue instructions when no register hazard is pending
// LD_WAIT | load requested; hold fetch until data returns or the wait times out
module ex_issue_sched #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [6:0]       instr_ctrl,
  input  logic [4:0]       instr_rd,
  input  logic [4:0]       instr_rs1,
  input  logic [4:0]       instr_rs2,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic             mem_rd_req,
  input  logic             mem_rd_valid,
  output logic             enable_ex,
  output logic [6:0]       control_out,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN, LD_WAIT} state_e;

  state_e           state_q;
  logic [31:0]      pending_q, pending_d;
  logic [CNT_W-1:0] stall_q;
  logic [TW-1:0]    to_cnt_q;
  logic             enable_ex_q, mem_rd_req_q, err_q;
  logic [6:0]       control_q, ld_ctrl_q;
  logic [4:0]       ex_rs1_q, ex_rs2_q, ld_rd_q, ld_rs1_q, ld_rs2_q;

  logic [2:0]  opsel;
  logic        imm;
  logic        is_shift, is_arith, is_load, is_store, is_op;
  logic        reads_rs2, writer, hazard, accept;
  logic        ld_data_ok, timeout_hit;
  logic [31:0] wbmask, eff;

  always_comb begin
    opsel     = instr_ctrl[2:0];
    imm       = instr_ctrl[3];
    is_shift  = (opsel == 3'd0);
    is_arith  = (opsel == 3'd1);
    is_load   = (opsel == 3'd5) && imm;
    is_store  = (opsel == 3'd4) && imm;
    is_op     = is_shift | is_arith | is_load | is_store;
    reads_rs2 = is_shift | is_store | (is_arith & ~imm);
    writer    = (is_shift | is_arith | is_load) && (instr_rd != 5'd0);
    wbmask    = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    eff       = pending_q & ~wbmask;
    hazard    = (is_op & eff[instr_rs1]) | (reads_rs2 & eff[instr_rs2]);
    instr_ready = (state_q == RUN) & ~hazard;
    accept    = instr_valid & instr_ready;
    // Memory holds stale valid until it sees our request, so ignore it during the request cycle.
    ld_data_ok  = mem_rd_valid & ~mem_rd_req_q;
    timeout_hit = (state_q == LD_WAIT) & ~ld_data_ok & (to_cnt_q == '0);
  end

  always_comb begin
    pending_d = pending_q & ~wbmask;
    if (timeout_hit) pending_d[ld_rd_q] = 1'b0;
    if (accept && writer) pending_d[instr_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      stall_q   <= '0;
    end else begin
      pending_q <= pending_d;
      if (instr_valid && !instr_ready && !(&stall_q)) stall_q <= stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      enable_ex_q  <= 1'b0;
      mem_rd_req_q <= 1'b0;
      err_q        <= 1'b0;
      control_q    <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ld_ctrl_q    <= '0;
      ld_rd_q      <= '0;
      ld_rs1_q     <= '0;
      ld_rs2_q     <= '0;
      to_cnt_q     <= '0;
    end else begin
      enable_ex_q  <= 1'b0;
      mem_rd_req_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (accept && is_load) begin
            ld_ctrl_q    <= instr_ctrl;
            ld_rd_q      <= instr_rd;
            ld_rs1_q     <= instr_rs1;
            ld_rs2_q     <= instr_rs2;
            to_cnt_q     <= TW'(MEM_TIMEOUT - 1);
            mem_rd_req_q <= 1'b1;
            state_q      <= LD_WAIT;
          end else if (accept && is_op) begin
            enable_ex_q <= 1'b1;
            control_q   <= instr_ctrl;
            ex_rs1_q    <= instr_rs1;
            ex_rs2_q    <= instr_rs2;
          end
        end
        LD_WAIT: begin
          if (ld_data_ok) begin
            enable_ex_q <= 1'b1;
            control_q   <= ld_ctrl_q;
            ex_rs1_q    <= ld_rs1_q;
            ex_rs2_q    <= ld_rs2_q;
            state_q     <= RUN;
          end else if (to_cnt_q == '0) begin
            err_q   <= 1'b1;
            state_q <= RUN;
          end else begin
            to_cnt_q <= to_cnt_q - 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign mem_rd_req  = mem_rd_req_q;
  assign enable_ex   = enable_ex_q;
  assign control_out = control_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign err_timeout = err_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_ex_issue_sched.sv
// Directed bench for ex_issue_sched: hazards, writeback bypass, load wait/timeout, saturation, reset.
module tb_ex_issue_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid, instr_ready;
  logic [6:0]  instr_ctrl;
  logic [4:0]  instr_rd, instr_rs1, instr_rs2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        mem_rd_req, mem_rd_valid;
  logic        enable_ex;
  logic [6:0]  control_out;
  logic [4:0]  ex_rs1, ex_rs2;
  logic        err_timeout;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  ex_issue_sched #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_ctrl(instr_ctrl),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .mem_rd_req(mem_rd_req), .mem_rd_valid(mem_rd_valid),
    .enable_ex(enable_ex), .control_out(control_out), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .err_timeout(err_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] c, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2);
    instr_valid = v; instr_ctrl = c; instr_rd = rd; instr_rs1 = r1; instr_rs2 = r2;
    #1;
  endtask

  task automatic wb(input logic v, input logic [4:0] r);
    wb_valid = v; wb_rd = r;
    #1;
  endtask

  initial begin
    reset = 1'b1; instr_valid = 0; instr_ctrl = 0; instr_rd = 0; instr_rs1 = 0; instr_rs2 = 0;
    wb_valid = 0; wb_rd = 0; mem_rd_valid = 0;
    tick(); tick();
    chk("rst_enable", enable_ex, 0);
    chk("rst_ctrl", control_out, 0);
    chk("rst_req", mem_rd_req, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_stall", stall_cnt, 0);
    reset = 1'b0;
    tick();

    // 1: RAW stall released by writeback
    drive(1, 7'h01, 5'd3, 5'd1, 5'd2);
    chk("t1_ready_a", instr_ready, 1);
    tick();
    chk("t1_en_a", enable_ex, 1);
    chk("t1_ctrl_a", control_out, 7'h01);
    chk("t1_rs1_a", ex_rs1, 1);
    chk("t1_rs2_a", ex_rs2, 2);
    drive(1, 7'h09, 5'd4, 5'd3, 5'd0);
    chk("t1_ready_stall", instr_ready, 0);
    tick();
    chk("t1_en_idle", enable_ex, 0);
    chk("t1_ready_stall2", instr_ready, 0);
    tick();
    wb(1, 5'd3);
    chk("t1_ready_wb", instr_ready, 1);
    tick();
    wb(0, 0); drive(0, 0, 0, 0, 0);
    chk("t1_en_b", enable_ex, 1);
    chk("t1_ctrl_b", control_out, 7'h09);
    chk("t1_rs1_b", ex_rs1, 3);
    chk("t1_stall", stall_cnt, 2);
    wb(1, 5'd4); tick(); wb(0, 0);
    chk("t1_en_off", enable_ex, 0);

    // 2: coincident writeback -> no stall
    drive(1, 7'h01, 5'd3, 5'd1, 5'd2);
    tick();
    drive(1, 7'h09, 5'd4, 5'd3, 5'd0);
    wb(1, 5'd3);
    chk("t2_ready", instr_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    wb(1, 5'd4);
    chk("t2_en", enable_ex, 1);
    chk("t2_ctrl", control_out, 7'h09);
    chk("t2_stall", stall_cnt, 2);
    tick(); wb(0, 0);

    // set beats clear on the same register
    drive(1, 7'h01, 5'd6, 5'd0, 5'd0);
    wb(1, 5'd6);
    tick();
    wb(0, 0);
    drive(1, 7'h09, 5'd0, 5'd6, 5'd0);
    chk("setwin_stall", instr_ready, 0);
    tick();
    wb(1, 5'd6);
    chk("setwin_wb", instr_ready, 1);
    tick();
    wb(0, 0); drive(0, 0, 0, 0, 0);
    chk("setwin_cnt", stall_cnt, 3);

    // 3: load, data three cycles after the request
    drive(1, 7'h0D, 5'd5, 5'd1, 5'd2);
    chk("t3_accept", instr_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("t3_req", mem_rd_req, 1);
    chk("t3_rdy1", instr_ready, 0);
    chk("t3_en1", enable_ex, 0);
    tick();
    chk("t3_req_off", mem_rd_req, 0);
    chk("t3_rdy2", instr_ready, 0);
    tick();
    chk("t3_rdy3", instr_ready, 0);
    tick();
    mem_rd_valid = 1; #1;
    chk("t3_rdy4", instr_ready, 0);
    tick();
    mem_rd_valid = 0; #1;
    chk("t3_en", enable_ex, 1);
    chk("t3_ctrl", control_out, 7'h0D);
    chk("t3_rs1", ex_rs1, 1);
    chk("t3_rdy5", instr_ready, 1);
    tick();
    chk("t3_en_pulse", enable_ex, 0);
    drive(1, 7'h09, 5'd0, 5'd5, 5'd0);
    chk("t3_pend5", instr_ready, 0);
    drive(0, 0, 0, 0, 0);
    wb(1, 5'd5); tick(); wb(0, 0);

    // 4: load timeout
    drive(1, 7'h0D, 5'd5, 5'd2, 5'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick();
    chk("t4_err_before", err_timeout, 0);
    chk("t4_rdy_before", instr_ready, 0);
    tick();
    chk("t4_err", err_timeout, 1);
    chk("t4_en", enable_ex, 0);
    drive(1, 7'h09, 5'd0, 5'd5, 5'd0);
    chk("t4_pend_clr", instr_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("t4_issue", enable_ex, 1);
    chk("t4_ctrl", control_out, 7'h09);

    // 5: r0 is never pending, then saturate stall counter
    drive(1, 7'h01, 5'd0, 5'd1, 5'd2);
    tick();
    drive(1, 7'h09, 5'd0, 5'd0, 5'd0);
    chk("t5_r0", instr_ready, 1);
    tick();
    chk("t5_cnt", stall_cnt, 3);
    drive(1, 7'h01, 5'd7, 5'd0, 5'd0);
    tick();
    drive(1, 7'h09, 5'd0, 5'd7, 5'd0);
    for (int i = 0; i < 65541; i++) tick();
    chk("t5_sat", stall_cnt, 16'hFFFF);
    drive(0, 0, 0, 0, 0);
    wb(1, 5'd7); tick(); wb(0, 0);

    // 6: reset in LD_WAIT
    drive(1, 7'h0D, 5'd5, 5'd1, 5'd2);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    reset = 1; #1;
    chk("t6_en", enable_ex, 0);
    chk("t6_req", mem_rd_req, 0);
    chk("t6_err", err_timeout, 0);
    chk("t6_ctrl", control_out, 0);
    chk("t6_stall", stall_cnt, 0);
    chk("t6_run", instr_ready, 1);
    tick();
    reset = 0;
    tick();
    drive(1, 7'h01, 5'd6, 5'd5, 5'd2);
    chk("t6_ready", instr_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("t6_issue", enable_ex, 1);
    chk("t6_ctrl2", control_out, 7'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
